// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multiply/divide unit: opcodes, FSM states
// and flag bit positions.
package cpu_pkg;

    localparam logic [5:0] OP_MUL = 6'h11;
    localparam logic [5:0] OP_DIV = 6'h12;
    localparam logic [5:0] OP_MOD = 6'h13;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_V = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the unsigned shift-add multiplier (LSB first)
// or the restoring divider (MSB first), selected by op.
module mdu_step
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [5:0]         op,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}.
        // Divide:   acc = {remainder, dividend bits shifting into quotient}.
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = rem - {1'b0, operand};
        acc_next = acc;
        if (op == OP_MUL) begin
            if (acc[0]) begin
                acc_next = {sum, acc[WIDTH-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*WIDTH-1:1]};
            end
        end else if (rem >= {1'b0, operand}) begin
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle unsigned MUL/DIV/MOD unit: latches operands on start, iterates
// WIDTH times through mdu_step, then registers result and flags.
module mdu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ALU_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               ready_q, ready_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic [3:0]         flags_q, flags_d;
    logic [2*WIDTH-1:0] step_acc;

    logic               load;
    logic [WIDTH-1:0]   res_n;
    logic [WIDTH-1:0]   hi_n;
    logic               v_n;

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op       (op_q),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (step_acc)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        ready_d     = ready_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        load        = 1'b0;
        res_n       = '0;
        hi_n        = '0;
        v_n         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && is_mdu_op(opcode)) begin
                    op_d    = opcode;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    ready_d = 1'b0;
                    if (opcode == OP_MUL) begin
                        acc_d  = {{WIDTH{1'b0}}, y};
                        opnd_d = x;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, x};
                        opnd_d = y;
                    end
                    // Divide by zero resolves immediately; ready stays low for DONE.
                    if (opcode != OP_MUL && y == '0) begin
                        state_d = DONE;
                        load    = 1'b1;
                        v_n     = 1'b1;
                        res_n   = (opcode == OP_DIV) ? {WIDTH{1'b1}} : x;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    load    = 1'b1;
                    unique case (op_q)
                        OP_MUL: begin
                            res_n = step_acc[WIDTH-1:0];
                            hi_n  = step_acc[2*WIDTH-1:WIDTH];
                        end
                        OP_DIV:  res_n = step_acc[WIDTH-1:0];
                        default: res_n = step_acc[2*WIDTH-1:WIDTH];
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            result_d       = res_n;
            result_hi_d    = hi_n;
            flags_d        = '0;
            flags_d[FLG_Z] = (res_n == '0);
            flags_d[FLG_N] = res_n[WIDTH-1];
            flags_d[FLG_C] = (op_d == OP_MUL) && (hi_n != '0);
            flags_d[FLG_V] = v_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            ready_q     <= 1'b1;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            ready_q     <= ready_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
        end
    end

    assign ALU_ready = ready_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

endmodule
